// File: rtl/regarb_pkg.sv
// ----------------------------------------------------------------------------
// regarb_pkg
// Shared types for the register write arbiter.
//   state_t      : arbiter FSM states (IDLE / WRITE / ACK)
//   req_id_t     : requester id, 1 bit (0 = requester 0, 1 = requester 1)
//   pick_winner  : arbitration decision for one IDLE cycle
// Configuration macro: REGARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie, last-served pointer ignored
//   undefined -> round-robin: on a tie the requester not served last wins
// ----------------------------------------------------------------------------
package regarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    typedef logic req_id_t;

    // Winner for the current request pair; only meaningful when r0 | r1.
    function automatic req_id_t pick_winner(
        input logic    r0,
        input logic    r1,
        input req_id_t last
    );
        req_id_t win;
        if (r0 && r1) begin
`ifdef REGARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last;
`endif
        end else if (r1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_shared_reg.sv
// ----------------------------------------------------------------------------
// shared_reg
// WIDTH-bit storage register written by the arbiter.
// Priority: rst > clr > ld; otherwise the value is held.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (q -> 0)
//   ld   : load enable (q <= d)
//   clr  : synchronous clear (q -> 0)
//   d    : load data
//   q    : register contents
// ----------------------------------------------------------------------------
module shared_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage register: reset/clear to zero, load on enable, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{1'b0}};
        end else if (clr) begin
            q <= {WIDTH{1'b0}};
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
// Arbitrates two level-held write requests onto one shared register.
// Each transaction: IDLE (sample) -> WRITE (grant, load at end) -> ACK
// (one-cycle ack, update last-served) -> IDLE.
// Ports:
//   CLK        : clock, rising edge
//   RES        : synchronous active-high reset (aborts any transaction)
//   req0/req1  : write requests, held until the matching ack
//   d0/d1      : write data of requester 0 / 1
//   clr        : clear of the shared register, honoured only in IDLE
//   gnt0/gnt1  : registered grant, high during WRITE for the winner
//   ack0/ack1  : registered one-cycle completion pulse during ACK
//   Q          : shared register contents
//   busy       : high whenever the FSM is not in IDLE
// Configuration macro: REGARB_FIXED_PRIO_EN (fixed priority to requester 0
// on ties instead of round-robin; see regarb_pkg::pick_winner).
// ----------------------------------------------------------------------------
module reg_write_arbiter
    import regarb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             clr,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] Q,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    req_id_t          r_win;
    req_id_t          r_last;
    logic [WIDTH-1:0] r_data;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_busy;

    req_id_t          w_win_sel;
    logic             w_start;
    logic             w_sr_clr;
    logic             w_sr_ld;
    logic             w_gnt0_nxt;
    logic             w_gnt1_nxt;
    logic             w_ack0_nxt;
    logic             w_ack1_nxt;

    // State register.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr in IDLE wins over requests and keeps us in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!clr && (req0 || req1)) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/enable decode; grant and ack values are next-cycle values
    // that get registered below so they line up with WRITE and ACK.
    always_comb begin
        w_win_sel  = pick_winner(req0, req1, r_last);
        w_start    = 1'b0;
        w_sr_clr   = 1'b0;
        w_sr_ld    = 1'b0;
        w_gnt0_nxt = 1'b0;
        w_gnt1_nxt = 1'b0;
        w_ack0_nxt = 1'b0;
        w_ack1_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_sr_clr = 1'b1;
                end else if (req0 || req1) begin
                    w_start    = 1'b1;
                    w_gnt0_nxt = (w_win_sel == 1'b0);
                    w_gnt1_nxt = (w_win_sel == 1'b1);
                end else begin
                    w_start = 1'b0;
                end
            end
            ST_WRITE: begin
                w_sr_ld    = 1'b1;
                w_ack0_nxt = (r_win == 1'b0);
                w_ack1_nxt = (r_win == 1'b1);
            end
            ST_ACK: begin
                w_start = 1'b0;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Transaction bookkeeping and registered outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_win  <= 1'b0;
            r_last <= 1'b1;
            r_data <= {WIDTH{1'b0}};
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_start) begin
                r_win  <= w_win_sel;
                r_data <= (w_win_sel == 1'b1) ? d1 : d0;
            end else begin
                r_win  <= r_win;
                r_data <= r_data;
            end
            if (r_state == ST_ACK) begin
                r_last <= r_win;
            end else begin
                r_last <= r_last;
            end
            r_gnt0 <= w_gnt0_nxt;
            r_gnt1 <= w_gnt1_nxt;
            r_ack0 <= w_ack0_nxt;
            r_ack1 <= w_ack1_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    shared_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk (CLK),
        .rst (RES),
        .ld  (w_sr_ld),
        .clr (w_sr_clr),
        .d   (r_data),
        .q   (Q)
    );

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign busy = r_busy;

endmodule
